// File: rtl/dmi_port_arbiter_if.sv
// dmi_port_arbiter_if: level request / one-cycle ack handshake used by the
// system-side requester of the DMI port arbiter.
//   s_req/s_wr/s_addr/s_wdata : request, held until s_ack (master drives)
//   s_ack/s_rdata             : completion pulse and read data (slave drives)
interface dmi_port_arbiter_if;
  localparam int unsigned AW = 7;
  localparam int unsigned DW = 32;

  logic          s_req;
  logic          s_wr;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_ack;
  logic [DW-1:0] s_rdata;

  modport master (output s_req, s_wr, s_addr, s_wdata, input s_ack, s_rdata);
  modport slave  (input s_req, s_wr, s_addr, s_wdata, output s_ack, s_rdata);
endinterface

// File: rtl/dmi_port_arbiter.sv
// dmi_port_arbiter: shares the core-side DMI register port between the JTAG
// synchronizer (one-entry buffered, cannot stall) and a system handshake
// master. Each access runs IDLE -> ISSUE -> WAIT(RD_LAT) -> DONE.
// Ports:
//   core_clk, core_rst_n          clock, async active-low reset
//   j_reg_en/_wr_en/_wr_addr/_wr_data  JTAG request pulse and payload
//   j_rd_data, j_ovf, j_ovf_clr   JTAG read data, sticky drop flag, clear
//   s_bus (slave modport)         system request/ack handshake
//   reg_en/_wr_en/_wr_addr/_wr_data, rd_data  port into the debug module
//   busy                          FSM not in IDLE
// Config macro: DMI_ARB_RR_EN selects round-robin; undefined gives fixed
// priority with the JTAG buffer always winning.
module dmi_port_arbiter #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic                 core_clk,
  input  logic                 core_rst_n,
  input  logic                 j_reg_en,
  input  logic                 j_reg_wr_en,
  input  logic [6:0]           j_reg_wr_addr,
  input  logic [31:0]          j_reg_wr_data,
  output logic [31:0]          j_rd_data,
  output logic                 j_ovf,
  input  logic                 j_ovf_clr,
  dmi_port_arbiter_if.slave    s_bus,
  output logic                 reg_en,
  output logic                 reg_wr_en,
  output logic [6:0]           reg_wr_addr,
  output logic [31:0]          reg_wr_data,
  input  logic [31:0]          rd_data,
  output logic                 busy
);
  localparam int unsigned AW = 7;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          owner_q;   // 1: system owns the access
  logic          op_q;      // 1: write
  logic          jb_vld_q;
  logic          jb_wr_q;
  logic [AW-1:0] jb_addr_q;
  logic [DW-1:0] jb_data_q;
  logic          reg_en_q;
  logic          reg_wr_en_q;
  logic [AW-1:0] reg_addr_q;
  logic [DW-1:0] reg_data_q;
  logic [DW-1:0] j_rd_data_q;
  logic [DW-1:0] s_rdata_q;
  logic          s_ack_q;
  logic          j_ovf_q;
  logic          busy_q;
`ifdef DMI_ARB_RR_EN
  logic          ptr_q;     // 1: system was granted last
`endif

  logic j_gnt;
  logic s_gnt;
  logic jb_load;
  logic jb_drop;

  // Grant decision in IDLE plus JTAG buffer load/drop qualification
  always_comb begin
    j_gnt = 1'b0;
    s_gnt = 1'b0;
    if (state_q == IDLE) begin
`ifdef DMI_ARB_RR_EN
      if (jb_vld_q && s_bus.s_req) begin
        j_gnt = ptr_q;
        s_gnt = !ptr_q;
      end else begin
        j_gnt = jb_vld_q;
        s_gnt = s_bus.s_req;
      end
`else
      j_gnt = jb_vld_q;
      s_gnt = s_bus.s_req && !jb_vld_q;
`endif
    end
    // A grant frees the entry in the same cycle, so a pulse can refill it.
    jb_load = j_reg_en && (!jb_vld_q || j_gnt);
    jb_drop = j_reg_en && jb_vld_q && !j_gnt;
  end

  // Access sequencer, JTAG buffer and all registered outputs
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      op_q        <= 1'b0;
      jb_vld_q    <= 1'b0;
      jb_wr_q     <= 1'b0;
      jb_addr_q   <= '0;
      jb_data_q   <= '0;
      reg_en_q    <= 1'b0;
      reg_wr_en_q <= 1'b0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      j_rd_data_q <= '0;
      s_rdata_q   <= '0;
      s_ack_q     <= 1'b0;
      j_ovf_q     <= 1'b0;
      busy_q      <= 1'b0;
`ifdef DMI_ARB_RR_EN
      ptr_q       <= 1'b1;
`endif
    end else begin
      reg_en_q    <= 1'b0;
      reg_wr_en_q <= 1'b0;
      s_ack_q     <= 1'b0;

      if (jb_load) begin
        jb_vld_q  <= 1'b1;
        jb_wr_q   <= j_reg_wr_en;
        jb_addr_q <= j_reg_wr_addr;
        jb_data_q <= j_reg_wr_data;
      end else if (j_gnt) begin
        jb_vld_q  <= 1'b0;
      end

      // A new drop outranks a coincident clear.
      if (jb_drop) begin
        j_ovf_q <= 1'b1;
      end else if (j_ovf_clr) begin
        j_ovf_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (j_gnt || s_gnt) begin
            state_q  <= ISSUE;
            busy_q   <= 1'b1;
            reg_en_q <= 1'b1;
            owner_q  <= s_gnt;
`ifdef DMI_ARB_RR_EN
            ptr_q    <= s_gnt;
`endif
            if (s_gnt) begin
              op_q        <= s_bus.s_wr;
              reg_wr_en_q <= s_bus.s_wr;
              reg_addr_q  <= s_bus.s_addr;
              reg_data_q  <= s_bus.s_wdata;
            end else begin
              op_q        <= jb_wr_q;
              reg_wr_en_q <= jb_wr_q;
              reg_addr_q  <= jb_addr_q;
              reg_data_q  <= jb_data_q;
            end
          end
        end
        ISSUE: begin
          state_q <= WAIT;
          cnt_q   <= CW'(RD_LAT - 1);
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
            // Response registers load here so they are visible during DONE.
            if (!op_q) begin
              if (owner_q) s_rdata_q   <= rd_data;
              else         j_rd_data_q <= rd_data;
            end
            if (owner_q) s_ack_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign reg_en        = reg_en_q;
  assign reg_wr_en     = reg_wr_en_q;
  assign reg_wr_addr   = reg_addr_q;
  assign reg_wr_data   = reg_data_q;
  assign j_rd_data     = j_rd_data_q;
  assign j_ovf         = j_ovf_q;
  assign busy          = busy_q;
  assign s_bus.s_ack   = s_ack_q;
  assign s_bus.s_rdata = s_rdata_q;
endmodule

// File: doc/dmi_port_arbiter.md
# dmi_port_arbiter

Shares the core-side DMI register port (reg_en / reg_wr_en / reg_wr_addr / reg_wr_data / rd_data into the debug module) between two requesters: the JTAG path arriving through the JTAG-to-core synchronizer, and a system-side handshake master such as a debug mailbox. It sits in the core_clk domain between the synchronizer outputs and the debug module. The JTAG requester cannot be back-pressured, so the block buffers it. The block sequences each access through a fixed-latency issue/wait/respond FSM and returns read data to the requester that owns the access.

## Interface
Parameters:
- RD_LAT, 1, cycles from reg_en to valid rd_data (legal 1..3)

Ports:
- core_clk  in  1  core clock
- core_rst_n  in  1  core reset, asynchronous, active-low
- j_reg_en  in  1  single-cycle request pulse from JTAG synchronizer
- j_reg_wr_en  in  1  JTAG request is a write (valid with j_reg_en)
- j_reg_wr_addr  in  7  JTAG register address
- j_reg_wr_data  in  32  JTAG write data
- j_rd_data  out  32  last JTAG read data, held
- j_ovf  out  1  sticky: JTAG request dropped
- j_ovf_clr  in  1  clears j_ovf
- s_req  in  1  system request, level, held until s_ack
- s_wr  in  1  system request is a write
- s_addr  in  7  system register address
- s_wdata  in  32  system write data
- s_ack  out  1  one-cycle completion pulse
- s_rdata  out  32  system read data, valid with s_ack, held after
- reg_en  out  1  access strobe to debug module
- reg_wr_en  out  1  write qualifier
- reg_wr_addr  out  7  address
- reg_wr_data  out  32  write data
- rd_data  in  32  read data from debug module
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: arbitrate the JTAG buffer (valid) against s_req. On a grant, latch op/addr/wdata into the output registers and go to ISSUE.
  - ISSUE: reg_en=1 for exactly one cycle, reg_wr_en=op; go to WAIT.
  - WAIT: count RD_LAT cycles. On the last count, capture rd_data into the response register (reads only); go to DONE.
  - DONE: deliver the response to the owner; go to IDLE.
- reg_wr_addr and reg_wr_data hold their value from grant until the next grant.
- Writes take the same path as reads; rd_data is ignored for writes.
- JTAG buffer, one entry:
  - A j_reg_en pulse loads the buffer if it is empty, or if it is freed in the same cycle.
  - The buffer is freed on the IDLE-cycle grant to JTAG.
  - A j_reg_en pulse while the buffer is full and not freeing is dropped, and j_ovf is set.
  - When j_ovf_clr and a new overflow occur in the same cycle, set wins.
- Response delivery in DONE:
  - JTAG read: j_rd_data is updated. JTAG write: j_rd_data is unchanged.
  - System access: s_ack=1. s_rdata is updated on reads only.
- s_req must stay high, with stable s_wr/s_addr/s_wdata, until s_ack. Dropping it early is a protocol violation, flagged by a bench assertion; the granted access still completes.
- A new s_req is eligible in the IDLE cycle after s_ack.
- Reset mid-transaction: the FSM returns to IDLE, the buffer empties, and the in-flight access is abandoned with no ack.

## Timing
- Reset values: reg_en, reg_wr_en, reg_wr_addr, reg_wr_data, j_rd_data, s_rdata, s_ack, j_ovf and busy are all 0. Arbitration pointer = "port 1 last granted".
- All outputs are registered.
- Grant in IDLE at cycle t:
  - reg_en high at t+1.
  - rd_data sampled at the end of cycle t+1+RD_LAT.
  - s_ack or j_rd_data update at t+2+RD_LAT.
  - Back in IDLE at t+3+RD_LAT.
- Back-to-back access spacing is RD_LAT+3 cycles.
- A j_reg_en arriving in IDLE with the buffer empty is granted the next cycle at the earliest; buffer load costs 1 cycle.
- busy is high from ISSUE through DONE inclusive.

## Configuration
- DMI_ARB_RR_EN defined: round-robin. When both requesters are pending in IDLE, grant the one not granted last; the pointer updates on every grant.
- DMI_ARB_RR_EN undefined: fixed priority, the JTAG buffer always wins. The system requester is served only when the buffer is empty. The pointer logic is removed.

## Test plan
- JTAG read addr 0x11, RD_LAT=1, rd_data=0xDEAD_BEEF in the sample cycle -> exactly one reg_en pulse with reg_wr_en=0 and addr 0x11; j_rd_data=0xDEAD_BEEF 3 cycles after grant; busy for 3 cycles.
- System write addr 0x10, data 0x8000_0001 -> one reg_en with reg_wr_en=1 and data 0x8000_0001; s_ack one cycle at t+3; s_rdata unchanged.
- JTAG and system pending together, twice, with DMI_ARB_RR_EN defined -> grant order JTAG, system, JTAG, system. Without the macro -> both JTAG accesses complete before the system access.
- Three j_reg_en pulses 1 cycle apart during a system access -> first buffered, second and third dropped; j_ovf=1 until j_ovf_clr; j_ovf_clr coincident with a new drop leaves j_ovf=1.
- core_rst_n asserted in WAIT -> all outputs 0 immediately; no s_ack; the next request after reset completes normally.
- RD_LAT=3 system read -> rd_data sampled 4 cycles after grant, s_ack at t+5; a value change on rd_data one cycle earlier is not captured.
